// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Used by both the transmit and receive halves of the UART subsystem.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  function automatic int clks_per_bit(
    input int clock_frequency,
    input int baud_rate
  );
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO.
// Queued bytes leave back-to-back: STOP hands straight over to START.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end

  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     rd_data;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           baud_done;

  assign in_ready  = rst && !full;
  assign push      = in_valid && in_ready;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign pop       = !empty &&
                     ((state == IDLE) ||
                      (state == STOP && baud_done));
  assign busy      = (state != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // tx follows the state one cycle later, keeping the line glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= rd_data;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= rd_data;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo with a line-level receiver model.
// Runs at a reduced bit period so the full loopback stays short.
module tb_uart_tx_fifo;

  localparam int CF    = 800;
  localparam int BR    = 100;
  localparam int DEPTH = 16;
  localparam int CPB   = CF / BR;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (CF),
    .BAUD_RATE       (BR),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int unsigned starts[$];
  int          frame_err = 0;

  // Line receiver: finds the start edge, samples mid-bit.
  initial begin
    logic [7:0]  b;
    bit          ok;
    int unsigned s;
    forever begin
      @(posedge clk);
      #1;
      if (rst && tx === 1'b0) begin
        s  = cyc;
        starts.push_back(s);
        ok = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (tx !== 1'b1) ok = 1'b0;
        if (ok) rx_q.push_back(b);
        else frame_err++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    rx_q.delete();
    starts.delete();
    frame_err = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, output int unsigned at);
    bit r;
    bit ok;
    int n;
    n  = 0;
    ok = 1'b0;
    at = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (n < 4 * FRAME * DEPTH) begin
      r = in_ready;
      tick();
      n++;
      if (r) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (ok) begin
      exp_q.push_back(b);
    end else begin
      n_checks++;
      $display("FAIL push_timeout: byte %02h never accepted", b);
    end
  endtask

  task automatic wait_rx(input int n, input int bound);
    int k;
    k = 0;
    while (rx_q.size() < n && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (10) tick();
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (fifo_count !== 5'd0)
      $display("FAIL reset_count: got %0d want 0", fifo_count);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0)
      $display("FAIL reset_ready: got %b want 0", in_ready);
    else n_pass++;
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL release_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (fifo_count !== 5'd0)
      $display("FAIL release_count: got %0d want 0", fifo_count);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [9:0]  fr;
    int unsigned at;
    int          errs;
    clear_model();
    fr = {1'b1, 8'h41, 1'b0};
    push_byte(8'h41, at);
    tick();
    n_checks++;
    if (tx !== 1'b1) $display("FAIL single_e1_tx: got %b want 1", tx);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy);
    else n_pass++;
    tick();
    for (int i = 0; i < 10; i++) begin
      errs = 0;
      for (int j = 0; j < CPB; j++) begin
        if (!(i == 0 && j == 0)) tick();
        if (tx !== fr[i]) errs++;
      end
      n_checks++;
      if (errs != 0)
        $display("FAIL single_bit%0d: %0d wrong cycles want 0 (level %b)",
                 i, errs, fr[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_done_busy: got %b want 0", busy);
    else n_pass++;
    tick();
    n_checks++;
    if (tx !== 1'b1) $display("FAIL single_idle_tx: got %b want 1", tx);
    else n_pass++;
    wait_rx(1, FRAME);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h41)
      $display("FAIL single_rx: got %0d bytes want 1 byte 41", rx_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned at;
    int          bad;
    clear_model();
    push_byte(8'h55, at);
    push_byte(8'hAA, at);
    push_byte(8'h00, at);
    wait_rx(3, 5 * FRAME);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (rx_q.size() != 3 || bad != 0)
      $display("FAIL b2b_data: got %0d bytes %0d wrong want 3 bytes 0 wrong",
               rx_q.size(), bad);
    else n_pass++;
    n_checks++;
    if (starts.size() < 3)
      $display("FAIL b2b_starts: got %0d want 3", starts.size());
    else n_pass++;
    if (starts.size() >= 3) begin
      n_checks++;
      if (starts[1] - starts[0] != FRAME || starts[2] - starts[1] != FRAME)
        $display("FAIL b2b_gap: got %0d,%0d want %0d,%0d",
                 starts[1] - starts[0], starts[2] - starts[1], FRAME, FRAME);
      else n_pass++;
    end
    n_checks++;
    if (frame_err != 0) $display("FAIL b2b_framing: got %0d want 0", frame_err);
    else n_pass++;
    wait_idle(4 * FRAME);
  endtask

  task automatic test_fill();
    int          idx;
    int          n;
    int          bad;
    bit          r;
    int unsigned acc18;
    clear_model();
    idx   = 0;
    n     = 0;
    acc18 = 0;
    in_valid = 1'b1;
    in_data  = 8'h00;
    while (idx < 18 && n < 30 * FRAME) begin
      r = in_ready;
      tick();
      n++;
      if (r) begin
        exp_q.push_back(in_data);
        idx++;
        if (idx == 18) acc18 = cyc;
        in_data = 8'(idx);
        if (idx == 17) begin
          n_checks++;
          if (fifo_count !== 5'd16)
            $display("FAIL fill_count: got %0d want 16", fifo_count);
          else n_pass++;
          n_checks++;
          if (in_ready !== 1'b0)
            $display("FAIL fill_ready: got %b want 0", in_ready);
          else n_pass++;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (idx != 18) $display("FAIL fill_accepted: got %0d want 18", idx);
    else n_pass++;
    n_checks++;
    if (starts.size() < 1 || acc18 - starts[0] != FRAME)
      $display("FAIL fill_18th_time: got %0d want %0d",
               starts.size() ? acc18 - starts[0] : 0, FRAME);
    else n_pass++;
    wait_rx(18, 22 * FRAME);
    bad = 0;
    for (int i = 0; i < 18; i++)
      if (i >= rx_q.size() || rx_q[i] !== 8'(i)) bad++;
    n_checks++;
    if (rx_q.size() != 18 || bad != 0)
      $display("FAIL fill_order: got %0d bytes %0d wrong want 18 bytes 0 wrong",
               rx_q.size(), bad);
    else n_pass++;
    wait_idle(4 * FRAME);
  endtask

  task automatic test_reset_mid();
    int unsigned at;
    int          lows;
    clear_model();
    push_byte(8'h0F, at);
    push_byte(8'h33, at);
    repeat (1 + 5 * CPB + CPB / 2) tick();
    n_checks++;
    if (tx !== 1'b0) $display("FAIL abort_in_bit4: got %b want 0", tx);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (tx !== 1'b1) $display("FAIL abort_tx: got %b want 1", tx);
    else n_pass++;
    n_checks++;
    if (fifo_count !== 5'd0)
      $display("FAIL abort_count: got %0d want 0", fifo_count);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
    else n_pass++;
    rst  = 1'b1;
    lows = 0;
    repeat (12 * CPB) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL abort_quiet: got %0d low cycles want 0", lows);
    else n_pass++;
    clear_model();
    push_byte(8'h41, at);
    wait_rx(1, 3 * FRAME);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h41 || frame_err != 0)
      $display("FAIL abort_recover: got %0d bytes err %0d want 1 byte 41",
               rx_q.size(), frame_err);
    else n_pass++;
    wait_idle(4 * FRAME);
  endtask

  task automatic test_loopback();
    int unsigned at;
    int          gap;
    int          bad;
    logic [7:0]  b;
    clear_model();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      push_byte(b, at);
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(0, 3 * FRAME);
      else gap = $urandom_range(0, 2);
      repeat (gap) tick();
    end
    wait_rx(256, 22 * FRAME);
    n_checks++;
    if (rx_q.size() != exp_q.size() || exp_q.size() != 256)
      $display("FAIL loop_size: got %0d want %0d", rx_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL loop_data: got %0d wrong want 0", bad);
    else n_pass++;
    n_checks++;
    if (frame_err != 0) $display("FAIL loop_framing: got %0d want 0", frame_err);
    else n_pass++;
    wait_idle(4 * FRAME);
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL loop_idle: got busy %b tx %b want 0 1", busy, tx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
